// File: rtl/datapath_pkg.sv
// Shared types for the register-file datapath: ALU opcodes and writeback mux select.
package datapath_pkg;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_SUB = 2'b10,
    ALU_ADD = 2'b11
  } alu_op_e;

  typedef enum logic {
    SEL_IMM = 1'b0,
    SEL_ALU = 1'b1
  } mux_sel_e;

endpackage

// File: rtl/datapath_rf_if.sv
// Command and result handshake bundle between the sequencer (master) and
// the register-file datapath (slave).
interface datapath_rf_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_sel;
  logic [1:0]       cmd_op;
  logic [AW-1:0]    cmd_rs;
  logic [AW-1:0]    cmd_rd;
  logic [WIDTH-1:0] cmd_imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             carry_out;
  logic             zero_out;

  modport master (
    output cmd_valid, cmd_sel, cmd_op, cmd_rs, cmd_rd, cmd_imm, out_ready,
    input  cmd_ready, out_valid, out_data, carry_out, zero_out
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_op, cmd_rs, cmd_rd, cmd_imm, out_ready,
    output cmd_ready, out_valid, out_data, carry_out, zero_out
  );
endinterface

// File: rtl/datapath_alu.sv
// Combinational WIDTH-bit ALU (AND/OR/SUB/ADD) with carry/borrow output.
// DATAPATH_SAT_EN: ADD clamps to all-ones on carry, SUB clamps to zero on borrow.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  // Extra top bit carries the ADD carry-out or the SUB borrow (a < b).
  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};

  // Operation select, with optional saturation on ADD/SUB.
  always_comb begin
    y     = {WIDTH{1'b0}};
    carry = 1'b0;
    case (op)
      ALU_AND: begin
        y     = a & b;
        carry = 1'b0;
      end
      ALU_OR: begin
        y     = a | b;
        carry = 1'b0;
      end
      ALU_SUB: begin
        carry = diff_s[WIDTH];
`ifdef DATAPATH_SAT_EN
        if (diff_s[WIDTH]) y = {WIDTH{1'b0}};
        else               y = diff_s[WIDTH-1:0];
`else
        y = diff_s[WIDTH-1:0];
`endif
      end
      ALU_ADD: begin
        carry = sum_s[WIDTH];
`ifdef DATAPATH_SAT_EN
        if (sum_s[WIDTH]) y = {WIDTH{1'b1}};
        else              y = sum_s[WIDTH-1:0];
`else
        y = sum_s[WIDTH-1:0];
`endif
      end
      default: begin
        y     = {WIDTH{1'b0}};
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/datapath_rf.sv
// DEPTH x WIDTH register-file datapath: execute stage + registered writeback/output
// stage with backpressure. Saturating arithmetic selectable via DATAPATH_SAT_EN.
module datapath_rf
  import datapath_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  datapath_rf_if.slave     bus,
  input  logic [AW-1:0]    rf_raddr,
  output logic [WIDTH-1:0] rf_rdata
);

  logic             e_valid_r;
  mux_sel_e         e_sel_r;
  alu_op_e          e_op_r;
  logic [AW-1:0]    e_rs_r;
  logic [AW-1:0]    e_rd_r;
  logic [WIDTH-1:0] e_imm_r;

  logic [WIDTH-1:0] rf_r [DEPTH];

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             carry_r;
  logic             zero_r;

  logic             advance_s;
  logic             cmd_ready_s;
  logic             accept_s;
  logic             wb_s;
  logic [WIDTH-1:0] alu_y_s;
  logic             alu_carry_s;
  logic [WIDTH-1:0] res_s;
  logic             res_carry_s;

  // Writeback and the next capture share an edge, so stage E always reads an up-to-date rf.
  assign advance_s   = !out_valid_r || bus.out_ready;
  assign cmd_ready_s = !e_valid_r || advance_s;
  assign accept_s    = bus.cmd_valid && cmd_ready_s;
  assign wb_s        = e_valid_r && advance_s;

  datapath_alu #(.WIDTH(WIDTH)) u_alu (
    .a     (rf_r[e_rs_r]),
    .b     (e_imm_r),
    .op    (e_op_r),
    .y     (alu_y_s),
    .carry (alu_carry_s)
  );

  // Writeback mux: immediate loads never report a carry.
  always_comb begin
    res_s       = e_imm_r;
    res_carry_s = 1'b0;
    if (e_sel_r == SEL_ALU) begin
      res_s       = alu_y_s;
      res_carry_s = alu_carry_s;
    end else begin
      res_s       = e_imm_r;
      res_carry_s = 1'b0;
    end
  end

  // Execute-stage command register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid_r <= 1'b0;
      e_sel_r   <= SEL_IMM;
      e_op_r    <= ALU_AND;
      e_rs_r    <= {AW{1'b0}};
      e_rd_r    <= {AW{1'b0}};
      e_imm_r   <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      e_valid_r <= 1'b1;
      e_sel_r   <= mux_sel_e'(bus.cmd_sel);
      e_op_r    <= alu_op_e'(bus.cmd_op);
      e_rs_r    <= bus.cmd_rs;
      e_rd_r    <= bus.cmd_rd;
      e_imm_r   <= bus.cmd_imm;
    end else if (wb_s) begin
      e_valid_r <= 1'b0;
    end
  end

  // Register file write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rf_r[i] <= {WIDTH{1'b0}};
    end else if (wb_s) begin
      rf_r[e_rd_r] <= res_s;
    end
  end

  // Output register; data and flags hold once the result has been taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
    end else if (wb_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= res_s;
      carry_r     <= res_carry_s;
      zero_r      <= (res_s == {WIDTH{1'b0}});
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.carry_out = carry_r;
  assign bus.zero_out  = zero_r;
  assign rf_rdata      = rf_r[rf_raddr];

endmodule

// File: tb/tb_datapath_rf.sv
// Self-checking bench for datapath_rf: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_datapath_rf;
  localparam int W    = 8;
  localparam int D    = 4;
  localparam int AW   = 2;
  localparam int FULL = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rf_raddr;
  logic [W-1:0]  rf_rdata;

  datapath_rf_if #(.WIDTH(W), .AW(AW)) bus ();

  datapath_rf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit sel;
    int op;
    int rs;
    int rd;
    int imm;
  } cmd_t;

  // Behavioural model: commands waiting to execute, register file, visible output.
  cmd_t pend[$];
  int   m_rf[D];
  bit   m_ov;
  bit   m_c;
  bit   m_z;
  int   m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void alu_model(input bit sel, input int op, input int a, input int b,
                                    output int res, output bit c);
    c   = 1'b0;
    res = b;
    if (sel) begin
      case (op)
        0: res = a & b;
        1: res = a | b;
        2: begin
          c   = (a < b);
          res = (a - b + FULL) % FULL;
`ifdef DATAPATH_SAT_EN
          if (c) res = 0;
`endif
        end
        default: begin
          c   = ((a + b) >= FULL);
          res = (a + b) % FULL;
`ifdef DATAPATH_SAT_EN
          if (c) res = FULL - 1;
`endif
        end
      endcase
    end
  endfunction

  task automatic model_reset();
    pend.delete();
    foreach (m_rf[i]) m_rf[i] = 0;
    m_ov = 1'b0; m_c = 1'b0; m_z = 1'b0; m_data = 0;
  endtask

  task automatic model_edge();
    bit   adv, rdy, c;
    int   r;
    cmd_t e;
    adv = !m_ov || bus.out_ready;
    rdy = (pend.size() == 0) || adv;
    if (pend.size() != 0 && adv) begin
      e = pend.pop_front();
      alu_model(e.sel, e.op, m_rf[e.rs], e.imm, r, c);
      m_rf[e.rd] = r;
      m_data = r; m_c = c; m_z = (r == 0); m_ov = 1'b1;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 1'b0;
    end
    if (bus.cmd_valid && rdy)
      pend.push_back('{bus.cmd_sel, int'(bus.cmd_op), int'(bus.cmd_rs), int'(bus.cmd_rd), int'(bus.cmd_imm)});
  endtask

  // Advance one clock; the model sees the same pre-edge inputs as the DUT.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input bit sel, input int op, input int rs, input int rd, input int imm);
    bus.cmd_valid = v;
    bus.cmd_sel   = sel;
    bus.cmd_op    = op[1:0];
    bus.cmd_rs    = rs[AW-1:0];
    bus.cmd_rd    = rd[AW-1:0];
    bus.cmd_imm   = imm[W-1:0];
  endtask

  task automatic issue_check(input string name, input bit sel, input int op, input int rs, input int rd,
                             input int imm, input int ed, input bit ec, input bit ez);
    drive(1'b1, sel, op, rs, rd, imm);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    tick();
    check({name, "_data"}, bus.out_data, ed);
    check({name, "_carry"}, bus.carry_out, ec);
    check({name, "_zero"}, bus.zero_out, ez);
    tick();
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    check("cmd_ready", bus.cmd_ready, (pend.size() == 0) || !m_ov || bus.out_ready);
    check("out_valid", bus.out_valid, m_ov);
    if (m_ov) begin
      check("out_data", bus.out_data, m_data);
      check("carry_out", bus.carry_out, m_c);
      check("zero_out", bus.zero_out, m_z);
    end
    check("rf_rdata", rf_rdata, m_rf[rf_raddr]);
  end

  initial begin
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    rf_raddr      = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_ovalid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_rf", rf_rdata, 0);

    // Load then accumulate.
    issue_check("load2", 1'b0, 3, 0, 0, 2, 2, 1'b0, 1'b0);
    issue_check("add3", 1'b1, 3, 0, 0, 3, 5, 1'b0, 1'b0);
    issue_check("add4", 1'b1, 3, 0, 0, 4, 9, 1'b0, 1'b0);
    rf_raddr = 2'd0; #1;
    check("rf0_9", rf_rdata, 9);

    // ADD overflow.
    issue_check("load200", 1'b0, 0, 0, 1, 200, 200, 1'b0, 1'b0);
`ifdef DATAPATH_SAT_EN
    issue_check("add_ovf", 1'b1, 3, 1, 1, 100, 255, 1'b1, 1'b0);
`else
    issue_check("add_ovf", 1'b1, 3, 1, 1, 100, 44, 1'b1, 1'b0);
`endif

    // SUB borrow and exact zero.
    issue_check("load3", 1'b0, 0, 0, 2, 3, 3, 1'b0, 1'b0);
`ifdef DATAPATH_SAT_EN
    issue_check("sub_brw", 1'b1, 2, 2, 2, 5, 0, 1'b1, 1'b1);
`else
    issue_check("sub_brw", 1'b1, 2, 2, 2, 5, 254, 1'b1, 1'b0);
`endif
    issue_check("load5", 1'b0, 0, 0, 2, 5, 5, 1'b0, 1'b0);
    issue_check("sub_zero", 1'b1, 2, 2, 2, 5, 0, 1'b0, 1'b1);

    // Back-to-back dependent commands.
    drive(1'b1, 1'b0, 0, 0, 0, 1);
    check("b2b_rdy0", bus.cmd_ready, 1);
    tick();
    drive(1'b1, 1'b1, 3, 0, 0, 1);
    check("b2b_rdy1", bus.cmd_ready, 1);
    tick();
    check("b2b_out1", bus.out_data, 1);
    check("b2b_rdy2", bus.cmd_ready, 1);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    check("b2b_out2", bus.out_data, 2);
    tick();
    check("b2b_out3", bus.out_data, 3);
    tick();

    // Backpressure: two results held, then drained in order.
    drive(1'b1, 1'b0, 0, 0, 3, 10);
    tick();
    drive(1'b1, 1'b1, 3, 3, 3, 1);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    bus.out_ready = 1'b0;
    rf_raddr = 2'd3; #1;
    check("bp_rdy", bus.cmd_ready, 0);
    check("bp_hold", bus.out_data, 10);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold", bus.out_data, 10);
      check("bp_rdy", bus.cmd_ready, 0);
      check("bp_nowr", rf_rdata, 10);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_second", bus.out_data, 11);
    check("bp_ov", bus.out_valid, 1);
    tick();
    check("bp_drained", bus.out_valid, 0);
    check("bp_rf", rf_rdata, 11);

    // Reset while both stages are occupied.
    drive(1'b1, 1'b0, 0, 0, 1, 33);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 0, 0, 2, 77);
    tick();
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    check("mr_ov_before", bus.out_valid, 1);
    rst = 1'b1;
    model_reset();
    rf_raddr = 2'd1;
    #1;
    check("mr_ov", bus.out_valid, 0);
    check("mr_data", bus.out_data, 0);
    check("mr_carry", bus.carry_out, 0);
    check("mr_zero", bus.zero_out, 0);
    check("mr_rf1", rf_rdata, 0);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("mr_rdy", bus.cmd_ready, 1);
    tick();
    tick();
    rf_raddr = 2'd2; #1;
    check("mr_no_ghost", bus.out_valid, 0);
    check("mr_rf2", rf_rdata, 0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      int imm;
      case ($urandom_range(0, 3))
        0:       imm = 0;
        1:       imm = FULL - 1;
        default: imm = $urandom_range(0, FULL - 1);
      endcase
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            $urandom_range(0, D - 1), $urandom_range(0, D - 1), imm);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rf_raddr = AW'($urandom_range(0, D - 1));
      tick();
    end
    drive(1'b0, 1'b0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/datapath_rf.md
# datapath_rf

Parametrised successor to the 4-bit accumulator datapath. It holds a DEPTH-entry, WIDTH-bit register file and adds a valid/ready command interface. Each command either loads an immediate or applies a 4-op ALU to (register, immediate), then writes the result back. The block runs a two-stage execute/writeback pipeline with output backpressure and registered carry/zero flags. It sits between the sequencer and the output bus.

## Interface
- WIDTH, 8, datapath width in bits (≥2)
- DEPTH, 4, register-file entries (power of 2, ≥2); AW = $clog2(DEPTH)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block accepts command this cycle
- cmd_sel  input  1  mux select: 0 = write cmd_imm directly, 1 = write ALU result
- cmd_op  input  2  ALU op: 00 AND, 01 OR, 10 SUB, 11 ADD
- cmd_rs  input  AW  source register (ALU operand A)
- cmd_rd  input  AW  destination register
- cmd_imm  input  WIDTH  immediate (mux input / ALU operand B)
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- out_data  output  WIDTH  value written to rf[rd]
- carry_out  output  1  carry (ADD) / borrow (SUB) of the result
- zero_out  output  1  out_data == 0
- rf_raddr  input  AW  debug read address
- rf_rdata  output  WIDTH  rf[rf_raddr], combinational

## Operation
- Stage E register holds: valid, sel, op, rs, rd, imm.
- advance = !out_valid || out_ready. cmd_ready = !e_valid || advance.
- Accept (cmd_valid && cmd_ready): command is latched into stage E.
- While e_valid, the ALU computes combinationally from A = rf[rs] and B = imm.
- On an edge with e_valid && advance:
  - rf[rd] ← res.
  - out_data ← res; carry_out, zero_out updated; out_valid ← 1.
  - Stage E then takes any new accepted command, or clears.
- On an edge with out_valid && out_ready && !e_valid: out_valid ← 0. out_data and flags hold.
- res = sel ? alu : imm. When sel=0, carry_out = 0.
- ALU results:
  - AND: A&B, carry 0.
  - OR: A|B, carry 0.
  - ADD: (A+B) mod 2^WIDTH, carry = bit WIDTH of the sum.
  - SUB: (A−B) mod 2^WIDTH, carry = 1 iff A<B (borrow).
- Hazards: a writeback and the next command's capture occur on the same edge, so the next stage-E read always sees the updated rf. No forwarding or stalls are needed for dependent commands.
- rd == rs is legal and uses the old value as operand A.
- Stall: while out_valid && !out_ready:
  - Stage E holds with no rf write.
  - cmd_ready = !e_valid.
  - out_* stay stable.
- Reset (async, any time):
  - All rf entries = 0.
  - e_valid = 0, out_valid = 0, out_data = 0, carry_out = 0, zero_out = 0.
  - cmd_ready = 1 after reset is released.
  - An in-flight command is discarded and does not write rf.

## Timing
- Latency: a command accepted at edge N produces out_valid and the rf write at edge N+1, provided advance holds during cycle N→N+1.
- Throughput: one command per cycle while out_ready = 1.
- rf_rdata reflects a write from the cycle following the write edge.
- No combinational path from cmd_* to out_*. cmd_ready depends combinationally on out_ready.

## Configuration
- DATAPATH_SAT_EN defined:
  - ADD overflow (carry=1) gives res = all-ones.
  - SUB underflow (borrow=1) gives res = 0.
  - carry_out still reports the raw carry/borrow.
- Undefined: ADD and SUB wrap modulo 2^WIDTH.

## Structure
- datapath_pkg holds:
  - alu_op_e enum: ALU_AND=2'b00, ALU_OR=2'b01, ALU_SUB=2'b10, ALU_ADD=2'b11.
  - mux_sel_e enum: SEL_IMM=0, SEL_ALU=1.
- Sub-module datapath_alu is the combinational WIDTH-parametrised ALU: (a, b, op) → (y, carry), with the saturation logic under DATAPATH_SAT_EN. It is instantiated once.

## Test plan
All cases use WIDTH=8, DEPTH=4, out_ready=1 unless stated.
- Load then accumulate: {sel=0, rd=0, imm=2} → out 2. {sel=1, ADD, rs=0, rd=0, imm=3} → 5. {ADD, imm=4} → 9. rf_rdata(0) = 9, carry 0.
- ADD overflow: r1 ← 200, then ADD imm=100 → out 44, carry 1, zero 0. With DATAPATH_SAT_EN: out 255, carry 1.
- SUB borrow/zero: r2 ← 3. SUB imm=5 → 254, carry 1 (SAT: 0, zero 1). Separately, r2 ← 5, SUB imm=5 → 0, carry 0, zero 1.
- Back-to-back dependent commands: three consecutive accepted cycles r0 ← 1, r0+1, r0+1 → outputs 1, 2, 3 on consecutive cycles. cmd_ready stays 1.
- Backpressure: out_ready=0 for 3 cycles after the first result. out_data is held, cmd_ready=0 once stage E is full, and no rf write occurs. Releasing out_ready drains both results in order, with no loss or duplication.
- Reset mid-operation: assert rst while e_valid=1 and out_valid=1 → all outputs and rf reads 0 immediately. After release, cmd_ready=1 and the discarded command never appears.
